// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte intake into a small FIFO, then 8E1-style framing
// (start, LSB-first data, even parity, stop) with each bit held OVERSAMPLE clocks.
module uart_tx #(
    parameter int WIDTH      = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          TxD,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] shift;
    logic             parity;
    logic [TW-1:0]    tick;
    logic [BW-1:0]    bit_cnt;
    logic             push;
    logic             pop;
    logic             tick_last;

    assign tx_ready  = (fifo_count != FULL);
    assign push      = tx_valid && tx_ready;
    assign tick_last = (tick == TICK_LAST);
    assign head      = mem[rd_ptr];
    // A new frame is loaded from IDLE or on the final STOP tick, so bursts run gap-free.
    assign pop       = (fifo_count != '0) &&
                       ((state == IDLE) || ((state == STOP) && tick_last));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            TxD     <= 1'b1;
            busy    <= 1'b0;
            tick    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            parity  <= 1'b0;
        end else begin
            tick <= ((state == IDLE) || tick_last) ? '0 : tick + TW'(1);
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift  <= head;
                        parity <= ^head;
                        TxD    <= 1'b0;
                        busy   <= 1'b1;
                        state  <= START;
                    end else begin
                        TxD  <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                START: begin
                    if (tick_last) begin
                        TxD     <= shift[0];
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (tick_last) begin
                        if (bit_cnt == BIT_LAST) begin
                            TxD   <= parity;
                            state <= PARITY;
                        end else begin
                            shift   <= shift >> 1;
                            TxD     <= shift[1];
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (tick_last) begin
                        TxD   <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (tick_last) begin
                        if (pop) begin
                            shift  <= head;
                            parity <= ^head;
                            TxD    <= 1'b0;
                            state  <= START;
                        end else begin
                            TxD   <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    TxD   <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: pushed bytes queue expected frames; a line monitor
// decodes TxD at mid-bit and each test task compares decoded frames and timing.
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int W     = 8;
    localparam int OS    = 16;
    localparam int FD    = 4;
    localparam int FRAME = (W + 3) * OS;

    typedef struct {
        logic [10:0] bits;
        int          start;
        bit          stable;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       TxD;
    logic       busy;
    logic [2:0] fifo_count;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         busy_cnt = 0;

    logic [7:0] exp_q[$];
    frame_t     rx_q[$];

    logic        mon_act = 1'b0;
    int          mon_k = 0;
    int          mon_start = 0;
    logic [10:0] mon_bits = '0;
    logic        mon_first = 1'b1;
    bit          mon_stable = 1'b1;

    uart_tx #(.WIDTH(W), .OVERSAMPLE(OS), .FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .TxD        (TxD),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (busy === 1'b1) busy_cnt++;

    // Line monitor: a low level starts a frame; each bit is sampled mid-bit and
    // every sample within a bit must agree with the first one.
    always @(negedge clk or negedge rst) begin
        if (rst !== 1'b1) begin
            mon_act = 1'b0;
        end else begin
            if (!mon_act && TxD === 1'b0) begin
                mon_act = 1'b1; mon_k = 0; mon_start = cyc;
                mon_bits = '0; mon_stable = 1'b1;
            end
            if (mon_act) begin
                if (mon_k % OS == 0) mon_first = TxD;
                else if (TxD !== mon_first) mon_stable = 1'b0;
                if (mon_k % OS == OS / 2) mon_bits[mon_k / OS] = TxD;
                if (mon_k == FRAME - 1) begin
                    rx_q.push_back('{mon_bits, mon_start, mon_stable});
                    mon_act = 1'b0;
                end
                mon_k++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic push_byte(input logic [7:0] d, output int acc);
        int n = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && n < 4 * FRAME) begin @(negedge clk); n++; end
        if (n >= 4 * FRAME) begin
            n_cmp++; n_bad++;
            $display("FAIL push_timeout: tx_ready=%b, want 1", tx_ready);
        end
        tx_data = d; tx_valid = 1'b1; acc = cyc + 1; exp_q.push_back(d);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_frame(output frame_t f, output bit ok);
        int n = 0;
        ok = 1'b0; f.bits = '0; f.start = -1; f.stable = 1'b0;
        while (rx_q.size() == 0 && n < 4 * FRAME) begin @(negedge clk); n++; end
        if (rx_q.size() != 0) begin f = rx_q.pop_front(); ok = 1'b1; end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        wait_cycles(3);
        n_cmp++; if (TxD !== 1'b1) begin n_bad++; $display("FAIL reset_txd: got %b want 1", TxD); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        rst = 1'b1;
    endtask

    task automatic test_idle_line();
        int txd_viol = 0;
        int busy_viol = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (TxD !== 1'b1) txd_viol++;
            if (busy !== 1'b0) busy_viol++;
        end
        n_cmp++; if (txd_viol != 0) begin n_bad++; $display("FAIL idle_txd: got %0d low/unknown cycles want 0", txd_viol); end
        n_cmp++; if (busy_viol != 0) begin n_bad++; $display("FAIL idle_busy: got %0d busy cycles want 0", busy_viol); end
        n_cmp++; if (rx_q.size() != 0) begin n_bad++; $display("FAIL idle_frames: got %0d frames want 0", rx_q.size()); end
    endtask

    task automatic test_single(input logic [7:0] d, input logic [10:0] literal_bits, input bit check_busy);
        int acc;
        frame_t f;
        bit ok;
        logic [7:0] e;
        logic [10:0] eb;
        busy_cnt = 0;
        push_byte(d, acc);
        wait_frame(f, ok);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        eb = {1'b1, ^e, e, 1'b0};
        n_cmp++;
        if (!ok || f.bits !== eb || !f.stable) begin
            n_bad++;
            $display("FAIL frame_%h: got bits=%b stable=%0d seen=%0d, want bits=%b stable=1", d, f.bits, f.stable, ok, eb);
        end
        n_cmp++;
        if (f.bits !== literal_bits) begin
            n_bad++; $display("FAIL pattern_%h: got %b want %b", d, f.bits, literal_bits);
        end
        n_cmp++;
        if (f.start !== acc + 1) begin
            n_bad++; $display("FAIL latency_%h: start edge got %0d want %0d", d, f.start, acc + 1);
        end
        wait_cycles(20);
        if (check_busy) begin
            n_cmp++;
            if (busy_cnt !== FRAME) begin
                n_bad++; $display("FAIL busy_len: got %0d cycles want %0d", busy_cnt, FRAME);
            end
        end
    endtask

    task automatic test_burst();
        logic [7:0] b[6] = '{8'h11, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h5A};
        int acc[6];
        int i = 0;
        int n = 0;
        int s0;
        logic [2:0] fc5 = '0;
        bit got = 1'b0;
        frame_t f;
        bit ok;
        logic [7:0] e;
        logic [10:0] eb;
        wait_cycles(20);
        @(negedge clk);
        while (i < 6 && n < 4 * FRAME) begin
            if (i == 5 && !got) begin fc5 = fifo_count; got = 1'b1; end
            tx_data = b[i]; tx_valid = 1'b1;
            if (tx_ready === 1'b1) begin
                acc[i] = cyc + 1; exp_q.push_back(b[i]); i++;
            end
            @(negedge clk); n++;
        end
        tx_valid = 1'b0;
        n_cmp++; if (i != 6) begin n_bad++; $display("FAIL burst_accept: got %0d accepted want 6", i); end
        for (int k = 1; k < 5; k++) begin
            n_cmp++;
            if (acc[k] !== acc[0] + k) begin
                n_bad++; $display("FAIL burst_edge%0d: got %0d want %0d", k, acc[k], acc[0] + k);
            end
        end
        n_cmp++; if (fc5 !== 3'd4) begin n_bad++; $display("FAIL burst_full: fifo_count got %0d want 4", fc5); end
        n_cmp++;
        if (acc[5] !== acc[0] + 2 + FRAME) begin
            n_bad++; $display("FAIL burst_sixth: accept edge got %0d want %0d", acc[5], acc[0] + 2 + FRAME);
        end
        s0 = acc[0] + 1;
        for (int k = 0; k < 6; k++) begin
            wait_frame(f, ok);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
            eb = {1'b1, ^e, e, 1'b0};
            n_cmp++;
            if (!ok || f.bits !== eb || !f.stable) begin
                n_bad++;
                $display("FAIL burst_frame%0d: got bits=%b stable=%0d seen=%0d, want bits=%b stable=1", k, f.bits, f.stable, ok, eb);
            end
            n_cmp++;
            if (f.start !== s0 + k * FRAME) begin
                n_bad++; $display("FAIL burst_start%0d: got %0d want %0d", k, f.start, s0 + k * FRAME);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc_x;
        int acc_y;
        int s0;
        int n = 0;
        frame_t f;
        bit ok;
        logic [7:0] e;
        logic [10:0] eb;
        wait_cycles(20);
        push_byte(8'hC3, acc_x);
        push_byte(8'h96, acc_y);
        s0 = acc_x + 1;
        while (cyc < s0 + FRAME - 1 && n < 2 * FRAME) begin @(negedge clk); n++; end
        n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL b2b_before: fifo_count got %0d want 1", fifo_count); end
        tx_data = 8'h4E; tx_valid = 1'b1; exp_q.push_back(8'h4E);
        @(negedge clk);
        tx_valid = 1'b0;
        n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL b2b_after: fifo_count got %0d want 1", fifo_count); end
        for (int k = 0; k < 3; k++) begin
            wait_frame(f, ok);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
            eb = {1'b1, ^e, e, 1'b0};
            n_cmp++;
            if (!ok || f.bits !== eb || !f.stable) begin
                n_bad++;
                $display("FAIL b2b_frame%0d: got bits=%b stable=%0d seen=%0d, want bits=%b stable=1", k, f.bits, f.stable, ok, eb);
            end
            n_cmp++;
            if (f.start !== s0 + k * FRAME) begin
                n_bad++; $display("FAIL b2b_start%0d: got %0d want %0d", k, f.start, s0 + k * FRAME);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int acc;
        int s0;
        int n = 0;
        int viol = 0;
        frame_t f;
        bit ok;
        logic [10:0] eb;
        wait_cycles(20);
        push_byte(8'hE1, acc);
        s0 = acc + 1;
        push_byte(8'h22, acc);
        push_byte(8'h33, acc);
        while (cyc < s0 + OS + 50 && n < 2 * FRAME) begin @(negedge clk); n++; end
        n_cmp++; if (fifo_count !== 3'd2) begin n_bad++; $display("FAIL rstmid_queued: fifo_count got %0d want 2", fifo_count); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (TxD !== 1'b1) begin n_bad++; $display("FAIL rstmid_txd: got %b want 1", TxD); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL rstmid_count: got %0d want 0", fifo_count); end
        n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", tx_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        wait_cycles(3);
        rst = 1'b1;
        exp_q.delete();
        rx_q.delete();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (TxD !== 1'b1 || busy !== 1'b0) viol++;
        end
        n_cmp++;
        if (viol != 0 || rx_q.size() != 0) begin
            n_bad++; $display("FAIL rstmid_quiet: got %0d active cycles %0d frames want 0 0", viol, rx_q.size());
        end
        push_byte(8'h6D, acc);
        wait_frame(f, ok);
        eb = {1'b1, ^exp_q[0], exp_q[0], 1'b0};
        void'(exp_q.pop_front());
        n_cmp++;
        if (!ok || f.bits !== eb || !f.stable || f.start !== acc + 1) begin
            n_bad++;
            $display("FAIL rstmid_resume: got bits=%b start=%0d seen=%0d, want bits=%b start=%0d", f.bits, f.start, ok, eb, acc + 1);
        end
    endtask

    initial begin
        test_reset();
        test_idle_line();
        test_single(8'hA5, 11'b10101001010, 1'b1);
        test_single(8'h07, 11'b11000001110, 1'b0);
        test_burst();
        test_back_to_back();
        test_reset_mid_frame();
        wait_cycles(20);
        n_cmp++;
        if (exp_q.size() != 0 || rx_q.size() != 0) begin
            n_bad++; $display("FAIL leftover: got %0d expected %0d received, want 0 0", exp_q.size(), rx_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmit stage of the UART, upstream of the UART receiver. It accepts parallel bytes over a valid/ready handshake into a small FIFO. It then serializes each byte onto `TxD` as a frame: one start bit, WIDTH data bits LSB-first, one even-parity bit and one stop bit. Each bit is held for OVERSAMPLE clocks, matching the receiver's 16x mid-bit sampling.

## Interface
- `WIDTH`, 8: data bits per frame; must be 8 to interoperate with the receiver.
- `OVERSAMPLE`, 16: clocks per serial bit; must be ≥2.
- `FIFO_DEPTH`, 4: holding-buffer entries; must be a power of two and ≥2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `tx_data`  in  WIDTH  byte to transmit.
- `tx_valid`  in  1  `tx_data` is valid this cycle.
- `tx_ready`  out  1  FIFO can accept; equals (fifo_count != FIFO_DEPTH), decoded from registered count.
- `TxD`  out  1  serial line, registered; idles high.
- `busy`  out  1  registered; 1 while the serializer state is not IDLE.
- `fifo_count`  out  clog2(FIFO_DEPTH)+1  entries currently held.

## Operation
- Reset (rst=0, asynchronous):
  - FIFO pointers and count go to 0, so `tx_ready` = 1.
  - `TxD` = 1, `busy` = 0, state = IDLE.
  - Tick counter, bit counter and shift register = 0.
- Push: `tx_valid && tx_ready` at an edge writes `tx_data` at the write pointer; the write pointer wraps modulo FIFO_DEPTH.
- `tx_valid` while full is ignored. Data is not captured, and the producer must hold it.
- Pop: when the serializer is ready for a new frame and count != 0, the head entry loads the shift register and the read pointer advances.
  - The serializer is ready in IDLE, or on the last STOP tick.
  - Parity register = XOR of the loaded byte (even parity).
- Simultaneous push and pop in one cycle: count unchanged; both pointers advance.
- States: IDLE, START, DATA, PARITY, STOP. The tick counter runs 0..OVERSAMPLE-1 in every non-IDLE state.
  - IDLE: `TxD`=1. If count != 0: pop, `TxD`<=0, go to START, tick<=0.
  - START: `TxD`=0. At tick==OVERSAMPLE-1: `TxD`<=shift[0], bit<=0, go to DATA.
  - DATA: at tick==OVERSAMPLE-1, if bit==WIDTH-1: `TxD`<=parity and go to PARITY; else shift right, `TxD`<=next bit, bit<=bit+1.
  - PARITY: at tick==OVERSAMPLE-1: `TxD`<=1, go to STOP.
  - STOP: at tick==OVERSAMPLE-1:
    - if count != 0: pop, `TxD`<=0 and go to START, giving back-to-back frames with no idle gap;
    - else go to IDLE.
- An undefined state recovers to IDLE with `TxD`=1.
- `busy` is registered alongside the state: 1 in START, DATA, PARITY and STOP.

## Timing
- Frame length = (WIDTH+3)*OVERSAMPLE clocks, which is 176 with the defaults.
- Latency with an empty FIFO and IDLE serializer:
  - byte accepted at edge N; count=1 after N;
  - pop at edge N+1, where `TxD` falls and `busy` rises.
- Bit boundaries fall every OVERSAMPLE edges after the start edge. The stop bit ends (WIDTH+3)*OVERSAMPLE edges after the start edge.
- `tx_ready` rises in the cycle after the pop edge that frees a slot. There is no combinational path from `tx_valid` to `tx_ready`.
- Reset asserted mid-frame:
  - `TxD` returns to 1 immediately, without waiting for a clock;
  - queued data is discarded;
  - after deassertion, the first frame starts only after a new push.

## Test plan
- Reset, then push 0xA5 once. `TxD` after the start edge, 16 cycles per bit: 0, data bits 1,0,1,0,0,1,0,1, parity 0, stop 1. `busy` is high for exactly 176 cycles.
- Push 0x07. Data bits are 1,1,1,0,0,0,0,0 and the parity bit is 1. Loop `TxD` into the receiver; it reports data 0x07 with no parity or stop error.
- Burst: push 6 bytes with `tx_valid` held high.
  - 5 are accepted on consecutive edges; the first pops the cycle after its push, leaving `fifo_count` = 4.
  - `tx_ready` stays low until the first frame's stop bit completes.
  - The 6th byte is accepted the cycle after that pop.
  - All 6 frames are emitted in order with no idle cycles between them.
- Simultaneous push and pop at the STOP-to-START boundary: `fifo_count` is unchanged, and the pushed byte is transmitted in order.
- Assert `rst` low during DATA of a frame with 2 entries queued. `TxD`=1 and `fifo_count`=0 with no clock needed. `tx_ready`=1 and `busy`=0. After release there is no frame until a new push.
- Idle line check: no pushes for 500 cycles after reset. `TxD` stays 1 and `busy` stays 0.
